gpr_writeback_arbiter: RTL and testbench
========================================

Name: gpr_writeback_arbiter

Overview:
- Producer side of the GPR write port: merges ALU results and load results into the single GPR write port (RegWrite, WriteRegister, WriteData).
- Loads have no backpressure and always win the port. ALU results carry a valid/ready handshake and wait in a small FIFO while loads occupy the port.
- Keeps a scoreboard of GPRs with loads in flight, used by the hazard/stall logic.
- Write-port outputs are registered on posedge clk, so they are stable at the GPR's negedge write.

Parameters:
- DEPTH, 4, ALU result FIFO entries; power of two, ≥2.
- DATA_W, 32, result data width.
- REG_W, 5, register index width.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous reset, active low.
- alu_valid  input  1  ALU result offered.
- alu_ready  output  1  FIFO can accept an ALU result this cycle.
- alu_reg  input  REG_W  ALU destination register.
- alu_data  input  DATA_W  ALU result.
- ld_valid  input  1  load data returning this cycle; cannot be stalled.
- ld_reg  input  REG_W  load destination register.
- ld_data  input  DATA_W  load data.
- ld_issue  input  1  load issued to memory; mark its destination pending.
- ld_issue_reg  input  REG_W  destination of the issued load.
- RegWrite  output  1  GPR write enable.
- WriteRegister  output  REG_W  GPR write index.
- WriteData  output  DATA_W  GPR write data.
- pending  output  32  scoreboard; bit r=1 means a load to r is in flight.
- q_count  output  $clog2(DEPTH)+1  current FIFO occupancy.
- err  output  1  sticky protocol error.

Behaviour:
- Reset (rst=0, asynchronous):
  - RegWrite=0, WriteRegister=0, WriteData=0.
  - FIFO emptied, q_count=0, pending=0, err=0.
  - Reset mid-operation discards queued ALU results and all pending bits.
- alu_ready = (q_count < DEPTH), computed from registered occupancy only.
  - When full, alu_ready=0 even if a pop occurs in the same cycle; there is no full-pop bypass.
- ALU push on alu_valid && alu_ready.
  - alu_reg==0: the handshake completes but nothing is enqueued.
- Write-port selection, evaluated every posedge:
  - ld_valid=1: the load is written; the FIFO does not pop.
  - else if FIFO non-empty: pop the head and write it.
  - else: RegWrite=0. WriteRegister and WriteData hold their last values.
- Load to register 0: RegWrite stays 0 that cycle, and the FIFO still does not pop.
- Latency:
  - Load: ld_valid cycle N → RegWrite=1 in cycle N+1.
  - ALU, empty FIFO, no loads: accepted cycle N → RegWrite=1 in cycle N+2. A same-cycle push is never popped in that cycle.
- Ordering:
  - FIFO is strictly in order.
  - Loads bypass the FIFO. The hazard unit must keep an ALU result and a load to the same register from both being outstanding, using pending.
- Simultaneous push and pop (not full): occupancy unchanged; the entries are distinct.
- Scoreboard:
  - ld_issue with ld_issue_reg≠0 sets pending[ld_issue_reg]; bit 0 is never set.
  - A load writeback to r clears pending[r].
  - Issue and writeback to the same r in one cycle: the set wins (a new load is in flight).
- err:
  - Set when ld_valid arrives with pending[ld_reg]=0 and ld_reg≠0. The write is still performed.
  - Cleared only by reset.
- Starvation: continuous ld_valid stalls the FIFO indefinitely. This is accepted; the memory system never returns loads on every cycle.

Decomposition:
- Shared package gpr_pkg:
  - REG_W, DATA_W, ZERO_REG=0.
  - typedef wb_req_t {reg idx, data}.
  - This package is also used by the GPR and the hazard unit.
- One sub-module: wb_fifo, a synchronous FIFO of wb_req_t with push, pop, count, full and empty, DEPTH parameterised.
- Arbitration, the write-port register and the scoreboard stay in the top module.

Test Plan:
- Reset then idle → RegWrite=0, pending=0, q_count=0, alu_ready=1. Assert rst=0 mid-burst with 3 entries queued → q_count=0 and no further writes.
- Single ALU push, reg 7, data 0xDEADBEEF, at cycle N → RegWrite=1, WriteRegister=7, WriteData=0xDEADBEEF in N+2 only.
- ld_issue reg 9, then ld_valid reg 9, data 0x1234 while ALU results to regs 3 and 4 are queued:
  - load written first and pending[9] clears;
  - reg 3 then reg 4 written in the next two cycles.
- Hold ld_valid for 6 cycles while pushing ALU results:
  - alu_ready drops after DEPTH=4 accepts;
  - queued results drain in order once loads stop.
- Writes to register 0: ALU push to reg 0 → accepted, q_count stays 0. ld_valid to reg 0 → RegWrite stays 0, err stays 0.
- Protocol checks:
  - ld_valid to reg 5 with pending[5]=0 → err=1, write performed.
  - Same-cycle ld_issue and ld_valid to reg 6 → pending[6] remains 1.

Source files
------------

// File: rtl/gpr_pkg.sv
// Types and constants shared by the GPR file, the hazard unit and the
// write-back arbiter.
package gpr_pkg;

   localparam int REG_W  = 5;
   localparam int DATA_W = 32;

   localparam logic [REG_W-1:0] ZERO_REG = '0;

   // One pending register write: destination index plus result data.
   typedef struct packed {
      logic [REG_W-1:0]  idx;
      logic [DATA_W-1:0] data;
   } wb_req_t;

endpackage

// File: rtl/gpr_writeback_arbiter_wb_fifo.sv
// Synchronous in-order FIFO of write-back requests. Push is ignored when
// full and pop is ignored when empty. The head entry is visible on dout
// without a pop.
module wb_fifo
   import gpr_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  wb_req_t                  din,
   input  logic                     pop,
   output wb_req_t                  dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   wb_req_t         mem_q [DEPTH];
   wb_req_t         mem_d [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            do_push;
   logic            do_pop;

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign dout  = mem_q[rd_ptr_q];

   // Next-state: write at the tail, advance pointers, track occupancy.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      do_push  = push && !full;
      do_pop   = pop && !empty;
      if (do_push) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (do_push && !do_pop) begin
         count_d = count_q + CW'(1);
      end else if (do_pop && !do_push) begin
         count_d = count_q - CW'(1);
      end
   end

   // State registers; reset empties the queue.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/gpr_writeback_arbiter.sv
// Merges ALU and load results onto the single GPR write port. Loads cannot
// be stalled and always take the port; ALU results queue in a FIFO and
// drain when no load is returning. Also tracks which GPRs have loads in
// flight so the hazard unit can stall dependent instructions.
//
// ALU handshake: a result transfers on a cycle where alu_valid and
// alu_ready are both high. alu_ready depends only on registered occupancy,
// so a full FIFO refuses data even in a cycle where it pops.
module gpr_writeback_arbiter
#(
   parameter int DEPTH  = 4,
   parameter int DATA_W = gpr_pkg::DATA_W,
   parameter int REG_W  = gpr_pkg::REG_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    alu_valid,
   output logic                    alu_ready,
   input  logic [REG_W-1:0]        alu_reg,
   input  logic [DATA_W-1:0]       alu_data,
   input  logic                    ld_valid,
   input  logic [REG_W-1:0]        ld_reg,
   input  logic [DATA_W-1:0]       ld_data,
   input  logic                    ld_issue,
   input  logic [REG_W-1:0]        ld_issue_reg,
   output logic                    RegWrite,
   output logic [REG_W-1:0]        WriteRegister,
   output logic [DATA_W-1:0]       WriteData,
   output logic [31:0]             pending,
   output logic [$clog2(DEPTH):0]  q_count,
   output logic                    err
);

   import gpr_pkg::*;

   wb_req_t              fifo_din;
   wb_req_t              fifo_head;
   logic                 fifo_push;
   logic                 fifo_pop;
   logic                 fifo_full;
   logic                 fifo_empty;

   logic                 reg_write_q, reg_write_d;
   logic [REG_W-1:0]     write_register_q, write_register_d;
   logic [DATA_W-1:0]    write_data_q, write_data_d;
   logic [31:0]          pending_q, pending_d;
   logic                 err_q, err_d;

   assign alu_ready      = !fifo_full;
   assign fifo_din.idx   = alu_reg;
   assign fifo_din.data  = alu_data;
   // Writes to r0 complete the handshake but are dropped here.
   assign fifo_push      = alu_valid && alu_ready && (alu_reg != ZERO_REG);
   // A returning load owns the port, even when it targets r0.
   assign fifo_pop       = !ld_valid && !fifo_empty;

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst),
      .push  (fifo_push),
      .din   (fifo_din),
      .pop   (fifo_pop),
      .dout  (fifo_head),
      .count (q_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Port selection, scoreboard update and sticky protocol error.
   always_comb begin
      reg_write_d      = 1'b0;
      write_register_d = write_register_q;
      write_data_d     = write_data_q;
      pending_d        = pending_q;
      err_d            = err_q;

      if (ld_valid) begin
         if (ld_reg != ZERO_REG) begin
            reg_write_d      = 1'b1;
            write_register_d = ld_reg;
            write_data_d     = ld_data;
            if (!pending_q[ld_reg]) begin
               err_d = 1'b1;
            end
         end
         pending_d[ld_reg] = 1'b0;
      end else if (fifo_pop) begin
         reg_write_d      = 1'b1;
         write_register_d = fifo_head.idx;
         write_data_d     = fifo_head.data;
      end

      // Set after clear so a same-cycle issue keeps the bit high.
      if (ld_issue && (ld_issue_reg != ZERO_REG)) begin
         pending_d[ld_issue_reg] = 1'b1;
      end
      pending_d[0] = 1'b0;
   end

   // Write-port and scoreboard registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         reg_write_q      <= 1'b0;
         write_register_q <= '0;
         write_data_q     <= '0;
         pending_q        <= '0;
         err_q            <= 1'b0;
      end else begin
         reg_write_q      <= reg_write_d;
         write_register_q <= write_register_d;
         write_data_q     <= write_data_d;
         pending_q        <= pending_d;
         err_q            <= err_d;
      end
   end

   assign RegWrite      = reg_write_q;
   assign WriteRegister = write_register_q;
   assign WriteData     = write_data_q;
   assign pending       = pending_q;
   assign err           = err_q;

endmodule

// File: tb/tb_gpr_writeback_arbiter.sv
// Directed bench for the GPR write-back arbiter.
module tb_gpr_writeback_arbiter;

   localparam int DEPTH  = 4;
   localparam int DATA_W = 32;
   localparam int REG_W  = 5;

   logic                   clk;
   logic                   rst;
   logic                   alu_valid;
   logic                   alu_ready;
   logic [REG_W-1:0]       alu_reg;
   logic [DATA_W-1:0]      alu_data;
   logic                   ld_valid;
   logic [REG_W-1:0]       ld_reg;
   logic [DATA_W-1:0]      ld_data;
   logic                   ld_issue;
   logic [REG_W-1:0]       ld_issue_reg;
   logic                   RegWrite;
   logic [REG_W-1:0]       WriteRegister;
   logic [DATA_W-1:0]      WriteData;
   logic [31:0]            pending;
   logic [$clog2(DEPTH):0] q_count;
   logic                   err;

   int checks;
   int errors;

   gpr_writeback_arbiter #(.DEPTH(DEPTH), .DATA_W(DATA_W), .REG_W(REG_W)) dut (
      .clk           (clk),
      .rst           (rst),
      .alu_valid     (alu_valid),
      .alu_ready     (alu_ready),
      .alu_reg       (alu_reg),
      .alu_data      (alu_data),
      .ld_valid      (ld_valid),
      .ld_reg        (ld_reg),
      .ld_data       (ld_data),
      .ld_issue      (ld_issue),
      .ld_issue_reg  (ld_issue_reg),
      .RegWrite      (RegWrite),
      .WriteRegister (WriteRegister),
      .WriteData     (WriteData),
      .pending       (pending),
      .q_count       (q_count),
      .err           (err)
   );

   // Clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock and settle just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      alu_valid    = 1'b0;
      alu_reg      = '0;
      alu_data     = '0;
      ld_valid     = 1'b0;
      ld_reg       = '0;
      ld_data      = '0;
      ld_issue     = 1'b0;
      ld_issue_reg = '0;
   endtask

   initial begin
      logic exp_ready;
      int   accepted;
      checks = 0;
      errors = 0;
      idle_inputs();
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();

      // Reset and idle.
      check("rst_regwrite", RegWrite, 0);
      check("rst_wreg", WriteRegister, 0);
      check("rst_wdata", WriteData, 0);
      check("rst_pending", pending, 0);
      check("rst_qcount", q_count, 0);
      check("rst_ready", alu_ready, 1);
      check("rst_err", err, 0);

      // Single ALU push: written two cycles after acceptance, once.
      alu_valid = 1'b1; alu_reg = 5'd7; alu_data = 32'hDEADBEEF;
      tick();
      idle_inputs();
      check("alu1_n1_regwrite", RegWrite, 0);
      check("alu1_n1_qcount", q_count, 1);
      tick();
      check("alu1_n2_regwrite", RegWrite, 1);
      check("alu1_n2_wreg", WriteRegister, 7);
      check("alu1_n2_wdata", WriteData, 32'hDEADBEEF);
      check("alu1_n2_qcount", q_count, 0);
      tick();
      check("alu1_n3_regwrite", RegWrite, 0);
      check("alu1_n3_wreg_hold", WriteRegister, 7);

      // Load to reg 9 overtakes ALU results to regs 3 and 4.
      ld_issue = 1'b1; ld_issue_reg = 5'd9;
      tick();
      idle_inputs();
      check("ld9_pending_set", pending, 32'h0000_0200);
      alu_valid = 1'b1; alu_reg = 5'd3; alu_data = 32'h3333;
      tick();
      alu_reg = 5'd4; alu_data = 32'h4444;
      ld_valid = 1'b1; ld_reg = 5'd9; ld_data = 32'h1234;
      tick();
      idle_inputs();
      check("ld9_regwrite", RegWrite, 1);
      check("ld9_wreg", WriteRegister, 9);
      check("ld9_wdata", WriteData, 32'h1234);
      check("ld9_pending_clr", pending, 0);
      check("ld9_qcount", q_count, 2);
      check("ld9_err", err, 0);
      tick();
      check("q3_wreg", WriteRegister, 3);
      check("q3_wdata", WriteData, 32'h3333);
      check("q3_qcount", q_count, 1);
      tick();
      check("q4_regwrite", RegWrite, 1);
      check("q4_wreg", WriteRegister, 4);
      check("q4_wdata", WriteData, 32'h4444);
      tick();
      check("q_empty_regwrite", RegWrite, 0);

      // Six back-to-back loads while ALU keeps offering results.
      ld_issue = 1'b1; ld_issue_reg = 5'd10;
      tick();
      accepted = 0;
      for (int k = 0; k < 6; k++) begin
         exp_ready = (accepted < DEPTH);
         check("burst_ready", alu_ready, exp_ready);
         alu_valid    = 1'b1;
         alu_reg      = REG_W'(20 + accepted);
         alu_data     = 32'hA000_0000 + accepted;
         ld_valid     = 1'b1;
         ld_reg       = REG_W'(10 + k);
         ld_data      = 32'hB000_0000 + k;
         ld_issue     = (k < 5);
         ld_issue_reg = REG_W'(11 + k);
         tick();
         if (exp_ready) accepted++;
         check("burst_wreg", WriteRegister, 10 + k);
         check("burst_wdata", WriteData, 32'hB000_0000 + k);
         check("burst_qcount", q_count, accepted);
      end
      idle_inputs();
      check("burst_accepted_full_ready", alu_ready, 0);
      check("burst_err", err, 0);
      check("burst_pending", pending, 0);
      for (int j = 0; j < 4; j++) begin
         tick();
         check("drain_regwrite", RegWrite, 1);
         check("drain_wreg", WriteRegister, 20 + j);
         check("drain_wdata", WriteData, 32'hA000_0000 + j);
      end
      tick();
      check("drain_done_regwrite", RegWrite, 0);
      check("drain_done_ready", alu_ready, 1);

      // Register 0 writes are dropped.
      alu_valid = 1'b1; alu_reg = 5'd0; alu_data = 32'hFFFF;
      check("r0_alu_ready", alu_ready, 1);
      tick();
      idle_inputs();
      check("r0_alu_qcount", q_count, 0);
      tick();
      check("r0_alu_regwrite", RegWrite, 0);
      ld_valid = 1'b1; ld_reg = 5'd0; ld_data = 32'h5A5A;
      tick();
      idle_inputs();
      check("r0_ld_regwrite", RegWrite, 0);
      check("r0_ld_err", err, 0);
      check("r0_ld_wreg_hold", WriteRegister, 23);

      // Unexpected load sets err but still writes.
      ld_valid = 1'b1; ld_reg = 5'd5; ld_data = 32'h5555;
      tick();
      idle_inputs();
      check("unexp_err", err, 1);
      check("unexp_regwrite", RegWrite, 1);
      check("unexp_wreg", WriteRegister, 5);
      check("unexp_wdata", WriteData, 32'h5555);

      // Same-cycle issue and return to reg 6: bit stays set.
      ld_issue = 1'b1; ld_issue_reg = 5'd6;
      tick();
      ld_valid = 1'b1; ld_reg = 5'd6; ld_data = 32'h6666;
      tick();
      idle_inputs();
      check("same6_pending", pending, 32'h0000_0040);
      check("same6_wreg", WriteRegister, 6);
      ld_valid = 1'b1; ld_reg = 5'd6; ld_data = 32'h6767;
      tick();
      idle_inputs();
      check("same6_pending_clr", pending, 0);
      check("err_sticky", err, 1);

      // Reset in the middle of a burst with three entries queued.
      ld_issue = 1'b1; ld_issue_reg = 5'd8;
      tick();
      for (int j = 0; j < 3; j++) begin
         alu_valid    = 1'b1;
         alu_reg      = REG_W'(1 + j);
         alu_data     = 32'hC000_0000 + j;
         ld_valid     = 1'b1;
         ld_reg       = 5'd8;
         ld_data      = 32'h8888;
         ld_issue     = 1'b1;
         ld_issue_reg = 5'd8;
         tick();
      end
      idle_inputs();
      check("midrst_pre_qcount", q_count, 3);
      check("midrst_pre_pending", pending, 32'h0000_0100);
      rst = 1'b0;
      #1;
      check("midrst_qcount", q_count, 0);
      check("midrst_regwrite", RegWrite, 0);
      check("midrst_pending", pending, 0);
      check("midrst_err", err, 0);
      tick();
      rst = 1'b1;
      for (int j = 0; j < 3; j++) begin
         tick();
         check("midrst_no_write", RegWrite, 0);
         check("midrst_empty", q_count, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
